// File: rtl/rice_core_register_file.sv
// Integer register file with busy-bit scoreboard; registered rs1/rs2 reads, separate writeback port.
// Optional same-cycle writeback forwarding enabled by defining RICE_CORE_REGISTER_FILE_BYPASS_EN.
module rice_core_register_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_read_valid,
  output logic            o_read_ready,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_rd_write,
  output logic            o_read_data_valid,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  input  logic            i_write_valid,
  input  logic [4:0]      i_write_rd,
  input  logic [XLEN-1:0] i_write_value,
  input  logic            i_flush
);

  // Entry 0 is never written, so it reads as zero without a special case.
  logic [XLEN-1:0] regs_q [32];
  logic [31:0]     busy_q, busy_d;
  logic            data_valid_q;
  logic [XLEN-1:0] rs1_value_q, rs2_value_q;

  logic            wr_en, rs1_fwd, rs2_fwd;
  logic            rs1_haz, rs2_haz, rd_haz;
  logic            accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    wr_en   = i_write_valid && (i_write_rd != 5'd0);
    rs1_fwd = wr_en && (i_write_rd == i_rs1);
    rs2_fwd = wr_en && (i_write_rd == i_rs2);
`ifdef RICE_CORE_REGISTER_FILE_BYPASS_EN
    rs1_haz = busy_q[i_rs1] && !rs1_fwd;
    rs2_haz = busy_q[i_rs2] && !rs2_fwd;
    rs1_val = rs1_fwd ? i_write_value : regs_q[i_rs1];
    rs2_val = rs2_fwd ? i_write_value : regs_q[i_rs2];
`else
    // A same-cycle write to a source costs one bubble since reads come only from the array.
    rs1_haz = busy_q[i_rs1] || rs1_fwd;
    rs2_haz = busy_q[i_rs2] || rs2_fwd;
    rs1_val = regs_q[i_rs1];
    rs2_val = regs_q[i_rs2];
`endif
    rd_haz       = i_rd_write && busy_q[i_rd] && !(wr_en && (i_write_rd == i_rd));
    o_read_ready = i_rst_n && !i_flush && !rs1_haz && !rs2_haz && !rd_haz;
    accept       = i_read_valid && o_read_ready;
  end

  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[i_write_rd] = 1'b0;
    if (i_flush) busy_d = '0;
    // Setting after clearing lets a new issue win over a same-edge writeback.
    if (accept && i_rd_write && (i_rd != 5'd0)) busy_d[i_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      regs_q       <= '{default: '0};
      busy_q       <= '0;
      data_valid_q <= 1'b0;
      rs1_value_q  <= '0;
      rs2_value_q  <= '0;
    end else begin
      if (wr_en) regs_q[i_write_rd] <= i_write_value;
      busy_q       <= busy_d;
      data_valid_q <= accept;
      if (accept) begin
        rs1_value_q <= rs1_val;
        rs2_value_q <= rs2_val;
      end
    end
  end

  assign o_read_data_valid = data_valid_q;
  assign o_rs1_value       = rs1_value_q;
  assign o_rs2_value       = rs2_value_q;

endmodule

// File: tb/tb_rice_core_register_file.sv
// Randomized self-checking bench for rice_core_register_file against an array/bitmask model.
module tb_rice_core_register_file;
  localparam int unsigned XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic            i_read_valid;
  logic            o_read_ready;
  logic [4:0]      i_rs1, i_rs2, i_rd;
  logic            i_rd_write;
  logic            o_read_data_valid;
  logic [XLEN-1:0] o_rs1_value, o_rs2_value;
  logic            i_write_valid;
  logic [4:0]      i_write_rd;
  logic [XLEN-1:0] i_write_value;
  logic            i_flush;

  rice_core_register_file #(.XLEN(XLEN)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_read_valid     (i_read_valid),
    .o_read_ready     (o_read_ready),
    .i_rs1            (i_rs1),
    .i_rs2            (i_rs2),
    .i_rd             (i_rd),
    .i_rd_write       (i_rd_write),
    .o_read_data_valid(o_read_data_valid),
    .o_rs1_value      (o_rs1_value),
    .o_rs2_value      (o_rs2_value),
    .i_write_valid    (i_write_valid),
    .i_write_rd       (i_write_rd),
    .i_write_value    (i_write_value),
    .i_flush          (i_flush)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];
  logic            m_dv;
  logic [XLEN-1:0] m_rs1, m_rs2;
  logic            m_acc;

`ifdef RICE_CORE_REGISTER_FILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit src_hazard(input logic [4:0] r);
    bit wmatch;
    if (r == 0) return 0;
    wmatch = i_write_valid && (i_write_rd == r);
    if (Bypass) return m_busy[r] && !wmatch;
    return m_busy[r] || wmatch;
  endfunction

  function automatic bit model_ready();
    bit rd_h;
    rd_h = i_rd_write && (i_rd != 0) && m_busy[i_rd] && !(i_write_valid && i_write_rd == i_rd);
    return i_rst_n && !i_flush && !src_hazard(i_rs1) && !src_hazard(i_rs2) && !rd_h;
  endfunction

  function automatic logic [XLEN-1:0] model_src(input logic [4:0] r);
    if (r == 0) return '0;
    if (Bypass && i_write_valid && i_write_rd == r) return i_write_value;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 0;
    end
    m_dv  = 0;
    m_rs1 = '0;
    m_rs2 = '0;
  endtask

  task automatic drive(input logic rst_n, input logic rv, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rdw,
                       input logic wv, input logic [4:0] wrd, input logic [XLEN-1:0] wval,
                       input logic flush);
    i_rst_n = rst_n; i_read_valid = rv; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_rd_write = rdw; i_write_valid = wv; i_write_rd = wrd; i_write_value = wval;
    i_flush = flush;
  endtask

  // One clock: check ready before the edge, advance the model, check registered outputs after.
  task automatic cycle(input string tag);
    bit              rdy;
    logic [XLEN-1:0] v1, v2;
    #1;
    rdy = model_ready();
    check_eq({tag, "_ready"}, o_read_ready, rdy);
    m_acc = i_read_valid && rdy;
    v1 = model_src(i_rs1);
    v2 = model_src(i_rs2);
    @(posedge i_clk);
    if (!i_rst_n) begin
      model_reset();
      m_acc = 0;
    end else begin
      m_dv = m_acc;
      if (m_acc) begin
        m_rs1 = v1;
        m_rs2 = v2;
      end
      if (i_write_valid && i_write_rd != 0) begin
        m_regs[i_write_rd] = i_write_value;
        m_busy[i_write_rd] = 0;
      end
      if (i_flush) for (int i = 0; i < 32; i++) m_busy[i] = 0;
      if (m_acc && i_rd_write && i_rd != 0) m_busy[i_rd] = 1;
    end
    #1;
    check_eq({tag, "_dv"}, o_read_data_valid, m_dv);
    check_eq({tag, "_rs1"}, o_rs1_value, m_rs1);
    check_eq({tag, "_rs2"}, o_rs2_value, m_rs2);
    @(negedge i_clk);
  endtask

  initial begin
    model_reset();
    m_acc = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, '0, 0);
    cycle("rst0");
    cycle("rst1");

    // Write x5 then read it back
    drive(1, 0, 0, 0, 0, 0, 1, 5, 32'h1234_5678, 0);
    cycle("wr_x5");
    drive(1, 1, 5, 0, 0, 0, 0, 0, '0, 0);
    cycle("rd_x5");
    check_eq("x5_dv", o_read_data_valid, 1'b1);
    check_eq("x5_val", o_rs1_value, 32'h1234_5678);
    check_eq("x5_rs2_zero", o_rs2_value, 32'h0);

    // x0 write dropped, rd=0 never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
    cycle("wr_x0");
    drive(1, 1, 0, 0, 0, 1, 0, 0, '0, 0);
    cycle("rd_x0");
    check_eq("x0_val", o_rs1_value, 32'h0);
    drive(1, 1, 0, 0, 0, 1, 0, 0, '0, 0);
    cycle("rd_x0_again");
    check_eq("x0_no_stall_dv", o_read_data_valid, 1'b1);

    // RAW on x7 released by writeback
    drive(1, 1, 0, 0, 7, 1, 0, 0, '0, 0);
    cycle("issue_x7");
    drive(1, 1, 7, 0, 0, 0, 0, 0, '0, 0);
    cycle("raw_stall");
    drive(1, 1, 7, 0, 0, 0, 1, 7, 32'hA5, 0);
    cycle("raw_wb");
    if (!m_acc) begin
      drive(1, 1, 7, 0, 0, 0, 0, 0, '0, 0);
      cycle("raw_late");
    end
    check_eq("raw_val", o_rs1_value, 32'hA5);

    // WAW on x3 released by same-cycle writeback; busy stays set
    drive(1, 1, 0, 0, 3, 1, 0, 0, '0, 0);
    cycle("issue_x3");
    drive(1, 1, 0, 0, 3, 1, 0, 0, '0, 0);
    cycle("waw_stall");
    drive(1, 1, 0, 0, 3, 1, 1, 3, 32'h33, 0);
    cycle("waw_wb");
    check_eq("waw_accepted", o_read_data_valid, 1'b1);
    drive(1, 1, 0, 0, 3, 1, 0, 0, '0, 0);
    cycle("waw_still_busy");

    // Flush cancels busy x9 (and x3)
    drive(1, 1, 0, 0, 9, 1, 0, 0, '0, 0);
    cycle("issue_x9");
    drive(1, 1, 0, 0, 0, 0, 0, 0, '0, 1);
    cycle("flush");
    check_eq("flush_dv", o_read_data_valid, 1'b0);
    drive(1, 1, 9, 3, 0, 0, 0, 0, '0, 0);
    cycle("after_flush");

    // Reset mid-operation discards busy x4
    drive(1, 1, 0, 0, 4, 1, 0, 0, '0, 0);
    cycle("issue_x4");
    drive(0, 1, 0, 0, 0, 0, 1, 6, 32'hDEAD, 0);
    cycle("mid_rst");
    drive(1, 1, 4, 6, 0, 0, 0, 0, '0, 0);
    cycle("after_rst");
    check_eq("rst_x4_val", o_rs1_value, 32'h0);
    check_eq("rst_x6_val", o_rs2_value, 32'h0);

    // Randomized traffic biased to a few registers so hazards are frequent
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] a, b, c, w;
      a = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      b = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      c = 5'($urandom_range(0, 7));
      w = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0), a, b, c,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w, XLEN'($urandom()),
            ($urandom_range(0, 39) == 0));
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rice_core_register_file.md
# rice_core_register_file

Integer register file with scoreboard for the rice core; it is the producer side of the operand values consumed by the execute-stage ALU. It accepts operand-read requests from decode through a valid/ready handshake, stalls on read-after-write and write-after-write hazards using per-register busy bits, and returns registered rs1/rs2 values one cycle later. Writeback results return through a separate write port, which updates the array and clears busy bits.

## Interface
- XLEN, 32, register width (32 or 64)
- i_clk  input  1  clock, all state on rising edge
- i_rst_n  input  1  reset, synchronous, active-low
- i_read_valid  input  1  decode presents a read request
- o_read_ready  output  1  request accepted this cycle when high with i_read_valid
- i_rs1  input  5  source register 1 index
- i_rs2  input  5  source register 2 index
- i_rd  input  5  destination index of the issuing instruction
- i_rd_write  input  1  issuing instruction writes i_rd
- o_read_data_valid  output  1  o_rs1_value/o_rs2_value valid this cycle
- o_rs1_value  output  XLEN  rs1 operand
- o_rs2_value  output  XLEN  rs2 operand
- i_write_valid  input  1  writeback strobe
- i_write_rd  input  5  writeback destination index
- i_write_value  input  XLEN  writeback data
- i_flush  input  1  pipeline flush; cancels all pending writes

## Operation
- Storage: x1..x31, XLEN each. x0 always reads 0; writes to x0 are dropped; busy[0] is never set.
- Writeback: when i_write_valid is high and i_write_rd≠0, the value is stored at the clock edge and busy[i_write_rd] is cleared. A write to a non-busy register is still stored.
- rs hazard: rsN≠0 and busy[rsN], unless this cycle's writeback covers it (see Configuration).
- rd hazard (WAW): i_rd_write, i_rd≠0, busy[i_rd], and there is no same-cycle i_write_valid to i_rd.
- o_read_ready = !i_flush && !rs1 hazard && !rs2 hazard && !rd hazard. The signal is combinational. It does not depend on i_read_valid.
- Accept (i_read_valid && o_read_ready):
  - Operand values are registered into o_rs1_value/o_rs2_value.
  - o_read_data_valid is driven high on the next cycle.
  - If i_rd_write and i_rd≠0, busy[i_rd] is set.
- Same-edge set and clear of the same busy bit: set wins.
- Without an accept, o_read_data_valid is 0 on the next cycle. o_rs*_value hold their last values.
- There is no downstream back-pressure. The consumer must take the data on the o_read_data_valid cycle.
- Flush:
  - All busy bits clear at the edge.
  - No request is accepted in the flush cycle.
  - o_read_data_valid is 0 on the following cycle.
  - A writeback in the flush cycle still updates the array.

## Timing
- Reset (i_rst_n low at edge):
  - All x1..x31 are 0 and all busy bits are 0.
  - o_read_data_valid=0, o_rs1_value=0, o_rs2_value=0.
  - o_read_ready is forced 0 while i_rst_n is low.
- Read latency: 1 cycle from accept to o_read_data_valid.
- Throughput: one accept per cycle when hazard-free.
- Reset mid-operation: pending busy bits and in-flight read data are discarded. Writebacks arriving in the reset cycle are ignored.
- Hazard release:
  - With bypass: in the same cycle as the matching writeback.
  - Without bypass: in the cycle after the matching writeback.

## Configuration
- Macro: RICE_CORE_REGISTER_FILE_BYPASS_EN.
- Defined:
  - When i_write_valid is high and i_write_rd equals a nonzero rsN, the rsN hazard is removed and i_write_value is forwarded into o_rsN_value on accept, whether or not the register was busy.
  - Release is zero-bubble.
- Undefined:
  - rsN matching a nonzero i_write_rd under i_write_valid counts as a hazard, so ready is low for that cycle.
  - Reads always come from the array, giving a one-cycle bubble after writeback.
  - The rd hazard rule is unchanged.

## Test plan
- Reset, then write x5=0x1234_5678; the next cycle read rs1=5, rs2=0 -> one cycle after accept: o_read_data_valid=1, o_rs1_value=0x1234_5678, o_rs2_value=0.
- Write x0=0xFFFF_FFFF, then read rs1=0 with i_rd_write=1, i_rd=0 -> o_rs1_value=0, no stall on a later read of x0.
- Issue rd=7; next request reads rs1=7 -> o_read_ready=0 until writeback x7=0xA5.
  - With bypass: accepted in the writeback cycle, o_rs1_value=0xA5.
  - Without bypass: accepted one cycle later, o_rs1_value=0xA5.
- Issue rd=3; next request has rd=3 -> stalled. A writeback to x3 in the same cycle as the second request -> accepted that cycle, busy[3] remains set.
- Issue rd=9, assert i_flush one cycle with i_read_valid high -> o_read_ready=0 in the flush cycle, no o_read_data_valid next cycle, a subsequent read of x9 is accepted immediately.
- Issue rd=4, pull i_rst_n low one cycle -> after reset a read of x4 is accepted immediately, o_rs1_value=0.
